// File: rtl/chimera_pmu_pkg.sv
// Shared definitions for the Chimera PMU: register map, STATUS layout,
// sequencer state encoding and the default APB request/response structs.
package chimera_pmu_pkg;

    localparam logic [3:0] REG_CMD    = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CLR    = 4'h8;

    localparam int unsigned CMD_DIR_BIT  = 31;
    localparam int unsigned ST_BUSY      = 16;
    localparam int unsigned ST_DONE      = 17;
    localparam int unsigned ST_TMO       = 18;
    localparam int unsigned ST_STATE_LSB = 20;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DN_ISO  = 3'd1,
        DN_GATE = 3'd2,
        DN_RST  = 3'd3,
        UP_CLK  = 3'd4,
        UP_RST  = 3'd5,
        UP_ISO  = 3'd6,
        DONE    = 3'd7
    } pmu_state_e;

    typedef struct packed {
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        pwrite;
        logic        penable;
        logic        psel;
    } pmu_apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } pmu_apb_rsp_t;

endpackage

// File: rtl/chimera_pmu_apb_regs.sv
// Zero-wait-state APB register file of the PMU: CMD / STATUS / CLR decode,
// done/timeout sticky bits and the sequencer start request.
module chimera_pmu_apb_regs
    import chimera_pmu_pkg::*;
#(
    parameter int unsigned NumDomains = 5,
    parameter type         apb_req_t  = pmu_apb_req_t,
    parameter type         apb_rsp_t  = pmu_apb_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  apb_req_t              apb_req_i,
    output apb_rsp_t              apb_rsp_o,
    input  logic [NumDomains-1:0] i_powered,
    input  logic                  i_busy,
    input  pmu_state_e            i_state,
    input  logic                  i_done_set,
    input  logic                  i_tmo_set,
    output logic                  o_start,
    output logic [NumDomains-1:0] o_start_mask,
    output logic                  o_start_dir,
    output logic                  o_irq
);

    logic                  r_done;
    logic                  r_tmo;
    logic                  w_access;
    logic                  w_err;
    logic                  w_cmd_wr;
    logic                  w_clr_wr;
    logic                  w_noop;
    logic [31:0]           w_status;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_unused = ^{apb_req_i.paddr, apb_req_i.pwdata, apb_req_i.pstrb};

    always_comb begin
        w_status                        = '0;
        w_status[NumDomains-1:0]        = i_powered;
        w_status[ST_BUSY]               = i_busy;
        w_status[ST_DONE]               = r_done;
        w_status[ST_TMO]                = r_tmo;
        w_status[ST_STATE_LSB +: 3]     = i_state;
    end

    always_comb begin
        w_access = apb_req_i.psel & apb_req_i.penable;
        w_err    = 1'b0;
        w_cmd_wr = 1'b0;
        w_clr_wr = 1'b0;
        w_rdata  = '0;
        if (w_access) begin
            if (apb_req_i.paddr[11:4] != '0) begin
                w_err = 1'b1;
            end else begin
                case (apb_req_i.paddr[3:0])
                    REG_CMD: begin
                        if (apb_req_i.pwrite) begin
                            w_err    = i_busy;
                            w_cmd_wr = ~i_busy;
                        end
                    end
                    REG_STATUS: begin
                        if (apb_req_i.pwrite) w_err = 1'b1;
                        else                  w_rdata = w_status;
                    end
                    REG_CLR:  w_clr_wr = apb_req_i.pwrite;
                    default:  w_err = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        apb_rsp_o         = '0;
        apb_rsp_o.pready  = w_access;
        apb_rsp_o.prdata  = w_rdata;
        apb_rsp_o.pslverr = w_err;
    end

    assign o_start_mask = apb_req_i.pwdata[NumDomains-1:0];
    assign o_start_dir  = apb_req_i.pwdata[CMD_DIR_BIT];
    // A command that would not change any selected domain completes on the spot.
    assign w_noop  = (o_start_mask & (o_start_dir ? ~i_powered : i_powered)) == '0;
    assign o_start = w_cmd_wr & ~w_noop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
            r_tmo  <= 1'b0;
        end else begin
            if (w_clr_wr && apb_req_i.pwdata[ST_DONE]) r_done <= 1'b0;
            if (i_done_set || (w_cmd_wr && w_noop))    r_done <= 1'b1;
            if (w_clr_wr && apb_req_i.pwdata[ST_TMO])  r_tmo  <= 1'b0;
            if (i_tmo_set)                             r_tmo  <= 1'b1;
        end
    end

    assign o_irq = r_done | r_tmo;

endmodule

// File: rtl/chimera_pmu_apb_ctrl.sv
// PMU power sequencer: drives per-domain isolation, clock gate and reset around
// an APB register file. States: IDLE | DN_ISO isolate+await ack | DN_GATE gate clk
// | DN_RST assert rst | UP_CLK ungate, rst held | UP_RST release rst | UP_ISO de-isolate+await ack | DONE.
module chimera_pmu_apb_ctrl
    import chimera_pmu_pkg::*;
#(
    parameter int unsigned NumDomains = 5,
    parameter int unsigned AckTimeout = 255,
    parameter int unsigned RstCycles  = 4,
    parameter type         apb_req_t  = pmu_apb_req_t,
    parameter type         apb_rsp_t  = pmu_apb_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  apb_req_t              apb_req_i,
    output apb_rsp_t              apb_rsp_o,
    output logic [NumDomains-1:0] dom_rst_no,
    output logic [NumDomains-1:0] dom_clkgate_en_o,
    output logic [NumDomains-1:0] dom_iso_en_o,
    input  logic [NumDomains-1:0] dom_iso_ack_i,
    output logic                  busy_o,
    output logic                  irq_o
);

    localparam int unsigned CntW = ($clog2(AckTimeout + 1) > $clog2(RstCycles + 1)) ?
                                   $clog2(AckTimeout + 1) : $clog2(RstCycles + 1);

    pmu_state_e            r_state, w_state_nxt;
    logic [NumDomains-1:0] r_mask, w_mask_nxt;
    logic [CntW-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [NumDomains-1:0] r_rst_n, w_rst_n_nxt;
    logic [NumDomains-1:0] r_cg, w_cg_nxt;
    logic [NumDomains-1:0] r_iso, w_iso_nxt;
    logic [NumDomains-1:0] r_powered, w_pwr_nxt;
    logic [NumDomains-1:0] r_ack_meta, r_ack_sync, w_ack_m;
    logic                  w_tmo_set;
    logic                  w_start, w_start_dir;
    logic [NumDomains-1:0] w_start_mask;

    chimera_pmu_apb_regs #(
        .NumDomains (NumDomains),
        .apb_req_t  (apb_req_t),
        .apb_rsp_t  (apb_rsp_t)
    ) u_regs (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .apb_req_i    (apb_req_i),
        .apb_rsp_o    (apb_rsp_o),
        .i_powered    (r_powered),
        .i_busy       (busy_o),
        .i_state      (r_state),
        .i_done_set   (r_state == DONE),
        .i_tmo_set    (w_tmo_set),
        .o_start      (w_start),
        .o_start_mask (w_start_mask),
        .o_start_dir  (w_start_dir),
        .o_irq        (irq_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack_meta <= '0;
            r_ack_sync <= '0;
        end else begin
            r_ack_meta <= dom_iso_ack_i;
            r_ack_sync <= r_ack_meta;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_cnt_inc   = r_cnt + CntW'(1);
        w_cnt_nxt   = r_cnt;
        w_rst_n_nxt = r_rst_n;
        w_cg_nxt    = r_cg;
        w_iso_nxt   = r_iso;
        w_pwr_nxt   = r_powered;
        w_tmo_set   = 1'b0;
        w_ack_m     = r_ack_sync & r_mask;
        case (r_state)
            // DONE lasts one cycle but accepts a new command just like IDLE.
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (w_start) begin
                    w_mask_nxt = w_start_mask;
                    w_cnt_nxt  = '0;
                    if (w_start_dir) begin
                        w_state_nxt = UP_CLK;
                        w_cg_nxt    = r_cg & ~w_start_mask;
                    end else begin
                        w_state_nxt = DN_ISO;
                        w_iso_nxt   = r_iso | w_start_mask;
                    end
                end
            end
            DN_ISO: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_ack_m == r_mask || w_cnt_inc == CntW'(AckTimeout)) begin
                    w_tmo_set   = (w_ack_m != r_mask);
                    w_state_nxt = DN_GATE;
                    w_cg_nxt    = r_cg | r_mask;
                end
            end
            DN_GATE: begin
                w_state_nxt = DN_RST;
                w_rst_n_nxt = r_rst_n & ~r_mask;
                w_pwr_nxt   = r_powered & ~r_mask;
            end
            DN_RST: w_state_nxt = DONE;
            UP_CLK: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == CntW'(RstCycles)) begin
                    w_state_nxt = UP_RST;
                    w_rst_n_nxt = r_rst_n | r_mask;
                    w_cnt_nxt   = '0;
                end
            end
            UP_RST: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == CntW'(RstCycles)) begin
                    w_state_nxt = UP_ISO;
                    w_iso_nxt   = r_iso & ~r_mask;
                    w_cnt_nxt   = '0;
                end
            end
            UP_ISO: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_ack_m == '0 || w_cnt_inc == CntW'(AckTimeout)) begin
                    w_tmo_set   = (w_ack_m != '0);
                    w_state_nxt = DONE;
                    w_pwr_nxt   = r_powered | r_mask;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_rst_n   <= '0;
            r_cg      <= '1;
            r_iso     <= '1;
            r_powered <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mask    <= w_mask_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rst_n   <= w_rst_n_nxt;
            r_cg      <= w_cg_nxt;
            r_iso     <= w_iso_nxt;
            r_powered <= w_pwr_nxt;
        end
    end

    assign dom_rst_no       = r_rst_n;
    assign dom_clkgate_en_o = r_cg;
    assign dom_iso_en_o     = r_iso;
    assign busy_o           = (r_state != IDLE) && (r_state != DONE);

endmodule

// File: tb/tb_chimera_pmu_apb_ctrl.sv
// Directed bench for the PMU sequencer: APB accesses, power up/down sequences,
// ack timeout, error responses and asynchronous reset mid-sequence.
module tb_chimera_pmu_apb_ctrl;
    import chimera_pmu_pkg::*;

    logic         clk_i;
    logic         rst_ni;
    pmu_apb_req_t apb_req;
    pmu_apb_rsp_t apb_rsp;
    logic [4:0]   dom_rst_n;
    logic [4:0]   dom_cg;
    logic [4:0]   dom_iso;
    logic [4:0]   dom_ack;
    logic         busy;
    logic         irq;

    int           n_cmp;
    int           n_err;
    int           cyc;
    logic         ack_stuck0;
    logic [4:0]   iso_hist [0:3];
    logic [31:0]  rd;
    logic         err;
    int           c0;
    logic         seen_idle;

    chimera_pmu_apb_ctrl dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .apb_req_i        (apb_req),
        .apb_rsp_o        (apb_rsp),
        .dom_rst_no       (dom_rst_n),
        .dom_clkgate_en_o (dom_cg),
        .dom_iso_en_o     (dom_iso),
        .dom_iso_ack_i    (dom_ack),
        .busy_o           (busy),
        .irq_o            (irq)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        iso_hist[0] <= dom_iso;
        for (int i = 1; i < 4; i++) iso_hist[i] <= iso_hist[i-1];
    end

    // Ack follows isolation enable three cycles later unless forced stuck low.
    assign dom_ack = ack_stuck0 ? 5'b00000 : iso_hist[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                            output logic [31:0] rdata, output logic serr);
        @(negedge clk_i);
        apb_req.psel    = 1'b1;
        apb_req.penable = 1'b0;
        apb_req.pwrite  = wr;
        apb_req.paddr   = addr;
        apb_req.pwdata  = wdata;
        apb_req.pstrb   = 4'hf;
        @(negedge clk_i);
        apb_req.penable = 1'b1;
        #1;
        rdata = apb_rsp.prdata;
        serr  = apb_rsp.pslverr;
        @(posedge clk_i);
        #1;
        apb_req.psel    = 1'b0;
        apb_req.penable = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        seen_idle = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #1;
            if (!busy) begin
                seen_idle = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen_idle}, 32'd1);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        cyc        = 0;
        ack_stuck0 = 1'b0;
        apb_req    = '0;
        rst_ni     = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset state
        chk("rst_rst_no", {27'd0, dom_rst_n}, 32'h00);
        chk("rst_cg",     {27'd0, dom_cg},    32'h1f);
        chk("rst_iso",    {27'd0, dom_iso},   32'h1f);
        chk("rst_busy",   {30'd0, busy, irq}, 32'h0);
        chk("rst_pready", {31'd0, apb_rsp.pready}, 32'h0);
        apb_xfer(32'h4, 32'h0, 1'b0, rd, err);
        chk("rst_status", rd, 32'h0);
        chk("rst_status_err", {31'd0, err}, 32'h0);

        // Power up domains 0 and 2
        apb_xfer(32'h0, 32'h8000_0005, 1'b1, rd, err);
        chk("up_cmd_err", {31'd0, err}, 32'h0);
        chk("up_cg",      {27'd0, dom_cg},    32'h1a);
        chk("up_rst_held",{27'd0, dom_rst_n}, 32'h00);
        chk("up_busy",    {31'd0, busy},      32'h1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("up_rst_still_held", {27'd0, dom_rst_n}, 32'h00);
        @(posedge clk_i);
        #1;
        chk("up_rst_rel", {27'd0, dom_rst_n}, 32'h05);
        chk("up_iso_held",{27'd0, dom_iso},   32'h1f);
        repeat (3) @(posedge clk_i);
        #1;
        chk("up_iso_still_held", {27'd0, dom_iso}, 32'h1f);
        @(posedge clk_i);
        #1;
        chk("up_iso_drop", {27'd0, dom_iso}, 32'h1a);
        wait_idle("up_complete", 50);
        apb_xfer(32'h4, 32'h0, 1'b0, rd, err);
        chk("up_status", rd, 32'h0002_0005);
        chk("up_irq", {31'd0, irq}, 32'h1);

        apb_xfer(32'h8, 32'h0002_0000, 1'b1, rd, err);
        apb_xfer(32'h4, 32'h0, 1'b0, rd, err);
        chk("clr_done_status", rd, 32'h0000_0005);
        chk("clr_done_irq", {31'd0, irq}, 32'h0);

        // Error responses
        apb_xfer(32'h10, 32'h0, 1'b1, rd, err);
        chk("err_addr10", {31'd0, err}, 32'h1);
        apb_xfer(32'hC, 32'h0, 1'b0, rd, err);
        chk("err_addrC", {31'd0, err}, 32'h1);
        apb_xfer(32'h4, 32'h0, 1'b1, rd, err);
        chk("err_status_wr", {31'd0, err}, 32'h1);
        apb_xfer(32'h0, 32'h0, 1'b0, rd, err);
        chk("cmd_read_zero", rd, 32'h0);

        // Command for an already powered domain completes immediately
        apb_xfer(32'h0, 32'h8000_0001, 1'b1, rd, err);
        chk("noop_err", {31'd0, err}, 32'h0);
        chk("noop_busy", {31'd0, busy}, 32'h0);
        chk("noop_outs", {17'd0, dom_rst_n, dom_cg, dom_iso}, {17'd0, 5'h05, 5'h1a, 5'h1a});
        apb_xfer(32'h4, 32'h0, 1'b0, rd, err);
        chk("noop_status", rd, 32'h0002_0005);
        apb_xfer(32'h8, 32'h0002_0000, 1'b1, rd, err);

        // Power down domain 0 with ack stuck low: timeout after 255 cycles in DN_ISO
        ack_stuck0 = 1'b1;
        apb_xfer(32'h0, 32'h0000_0001, 1'b1, rd, err);
        c0 = cyc;
        chk("dn_iso", {27'd0, dom_iso}, 32'h1b);
        apb_xfer(32'h0, 32'h0000_0004, 1'b1, rd, err);
        chk("busy_cmd_err", {31'd0, err}, 32'h1);
        wait_idle("dn_complete", 400);
        chk("dn_cycles", cyc - c0, 32'd257);
        chk("dn_outs", {17'd0, dom_rst_n, dom_cg, dom_iso}, {17'd0, 5'h04, 5'h1b, 5'h1b});
        apb_xfer(32'h4, 32'h0, 1'b0, rd, err);
        chk("dn_status", rd, 32'h0006_0004);
        apb_xfer(32'h8, 32'h0004_0000, 1'b1, rd, err);
        apb_xfer(32'h4, 32'h0, 1'b0, rd, err);
        chk("clr_tmo_status", rd, 32'h0002_0004);
        apb_xfer(32'h8, 32'h0006_0000, 1'b1, rd, err);
        chk("clr_all_irq", {31'd0, irq}, 32'h0);
        ack_stuck0 = 1'b0;

        // Reset asserted while in UP_RST
        apb_xfer(32'h0, 32'h8000_0002, 1'b1, rd, err);
        repeat (6) @(posedge clk_i);
        #1;
        chk("mid_rst_no", {27'd0, dom_rst_n}, 32'h06);
        chk("mid_cg",     {27'd0, dom_cg},    32'h19);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_outs", {17'd0, dom_rst_n, dom_cg, dom_iso}, {17'd0, 5'h00, 5'h1f, 5'h1f});
        chk("arst_busy", {30'd0, busy, irq}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        apb_xfer(32'h4, 32'h0, 1'b0, rd, err);
        chk("arst_status", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
